frame_encoder_param: RTL and testbench
======================================

// Module: frame_encoder_param
// PURPOSE
//  Parametrised successor to the fixed 10-char trigger frame encoder.
//  - Builds SOF_K | PAYLOAD_LEN data bytes | CRC-8 | EOF_K frames from a valid/ready byte stream.
//  - Fills gaps with IDLE_K; aborts a frame on source underrun.
//  - Emits one 8b10b character (byte + K flag) per enabled cycle to the downstream Encoder8b10b.
// PARAMETERS
//  PAYLOAD_LEN  7      data bytes per frame, legal range 1..255 (frame = PAYLOAD_LEN+3 chars)
//  CRC_POLY     8'h07  CRC-8 polynomial (MSB-first, no reflection, no final XOR)
//  CRC_INIT     8'hFF  CRC seed loaded at SOF
//  MIN_IDLE     1      minimum IDLE_K chars between EOF/ABORT and the next SOF, >=1
//  SOF_K        8'h3C  start-of-frame K char (K28.1)
//  EOF_K        8'hFD  end-of-frame K char (K29.7)
//  IDLE_K       8'hBC  idle/comma K char (K28.5)
//  ABORT_K      8'hFE  abort K char (K30.7)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  tx_ce        in   1   character-rate enable; all state frozen while 0
//  s_data       in   8   payload byte
//  s_valid      in   1   s_data valid
//  s_ready      out  1   byte consumed at this edge when s_valid & s_ready
//  tx_char      out  8   registered character to the 8b10b encoder
//  tx_k         out  1   registered K flag for tx_char
//  underrun     out  1   one-cycle pulse when a frame is aborted
//  frames_sent  out  16  count of completed frames (EOF emitted), wraps at 16'hFFFF->0
// BEHAVIOUR
//  - Reset: state=IDLE; tx_char=IDLE_K; tx_k=1; s_ready=0; underrun=0; frames_sent=0; idle_cnt=0.
//    Reset mid-frame drops the frame at once with no ABORT_K. Reset dominates tx_ce.
//  - Timing: each edge with tx_ce=1 registers the char of the current state into tx_char/tx_k
//    and advances state. Latency from byte acceptance to tx_char is 1 cycle.
//  - tx_ce=0: tx_char, tx_k, state and counters hold. s_ready=0. underrun is 0 for that cycle.
//  - s_ready = tx_ce & (state==PAYLOAD) & ~reset. Combinational, no dependence on s_valid.
//  - IDLE:
//    - char IDLE_K, k=1; idle_cnt increments, saturating at MIN_IDLE.
//    - -> SOF if s_valid & (idle_cnt+1 >= MIN_IDLE); else stay.
//    - s_data is not consumed here.
//  - SOF:
//    - char SOF_K, k=1; crc<=CRC_INIT; byte_cnt<=0.
//    - -> PAYLOAD unconditionally.
//  - PAYLOAD with s_valid=1:
//    - char s_data, k=0; crc<=crc8(crc,s_data); byte_cnt++.
//    - -> CRC when byte_cnt==PAYLOAD_LEN-1.
//  - PAYLOAD with s_valid=0 (underrun):
//    - char ABORT_K, k=1; underrun=1; idle_cnt<=0.
//    - -> IDLE; no CRC or EOF is sent.
//  - CRC:
//    - char crc (covers payload bytes only; SOF/EOF excluded), k=0.
//    - -> EOF.
//  - EOF:
//    - char EOF_K, k=1; frames_sent++ (wrapping); idle_cnt<=0.
//    - -> IDLE.
//  - No back-to-back frames: at least MIN_IDLE IDLE_K chars always separate EOF/ABORT from SOF.
//  - Widths:
//    - byte_cnt is $clog2(PAYLOAD_LEN+1) bits.
//    - idle_cnt is $clog2(MIN_IDLE+1) bits.
//    - compares are unsigned.
// STRUCTURE
//  - Package ps_frame_pkg holds:
//    - K-char localparams (K28_1, K28_5, K29_7, K30_7);
//    - state enum {IDLE,SOF,PAYLOAD,CRC,EOF};
//    - crc8_step function.
//  - Sub-module frame_crc8 (params POLY, INIT): registered CRC with init, enable and byte-in.
//    Provides a combinational next-value output so the CRC state can use the value for the current byte.
//  - Encoder8b10b stays outside this block, instantiated at the same level as it.
// TESTING
//  1 Reset then 20 cycles of s_valid=0 -> tx_char=8'hBC, tx_k=1 every cycle; s_ready never high; frames_sent=0.
//  2 PAYLOAD_LEN=1, s_data=8'h00 held valid
//    -> chars 3C(K), 00, F3, FD(K), BC(K), then 3C again; frames_sent increments per frame.
//  3 PAYLOAD_LEN=1, s_data=8'hFF -> CRC char 8'h00.
//    Default LEN=7 -> exactly 10 chars from SOF to EOF inclusive, with 7 s_ready handshakes.
//  4 Default LEN=7, s_valid dropped after 3 payload bytes -> next char FE(K); underrun pulses 1 cycle;
//    then >=MIN_IDLE BC chars before the next SOF; frames_sent unchanged.
//  5 tx_ce toggled 1010... mid-frame -> char sequence identical to tx_ce=1 case, each char held 2 cycles.
//    No byte is accepted while tx_ce=0.
//  6 reset asserted during PAYLOAD -> next edge tx_char=BC, tx_k=1.
//    The next frame starts with SOF and its CRC restarts from 8'hFF. frames_sent=0.
//    MIN_IDLE=4 -> exactly 4 BC chars between EOF and the following SOF with s_valid held.

Source files
------------

// File: rtl/ps_frame_pkg.sv
// Shared definitions for the parametrised frame encoder.
//   - 8b10b K-character codes used for framing
//   - frame sequencing state type
//   - single-byte CRC-8 step (MSB-first, no reflection)
package ps_frame_pkg;

  localparam logic [7:0] K28_1 = 8'h3C;  // start of frame
  localparam logic [7:0] K28_5 = 8'hBC;  // idle / comma
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] K30_7 = 8'hFE;  // abort

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    PAYLOAD,
    CRC,
    EOF
  } state_t;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_crc8.sv
// Registered CRC-8 accumulator.
//   clk, reset : system clock, synchronous active-high reset (loads INIT)
//   init       : load INIT at this edge (has priority over en)
//   en         : fold data into the CRC at this edge
//   data       : byte to fold in
//   crc_next   : combinational next value; equals the held CRC when init=en=0
module frame_crc8
  import ps_frame_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  logic [7:0] crc_q;

  always_comb begin
    crc_next = crc_q;
    if (init)    crc_next = INIT;
    else if (en) crc_next = crc8_step(crc_q, data, POLY);
  end

  always_ff @(posedge clk) begin
    if (reset) crc_q <= INIT;
    else       crc_q <= crc_next;
  end

endmodule

// File: rtl/frame_encoder_param.sv
// Frame encoder: SOF_K | PAYLOAD_LEN data bytes | CRC-8 | EOF_K, IDLE_K fill,
// ABORT_K on source underrun. One character (byte + K flag) per tx_ce cycle.
//   clk, reset   : system clock, synchronous active-high reset
//   tx_ce        : character-rate enable; all state frozen while 0
//   s_data       : payload byte
//   s_valid      : s_data valid
//   s_ready      : byte consumed at this edge when s_valid & s_ready
//   tx_char/tx_k : registered character and K flag to the 8b10b encoder
//   underrun     : one-cycle pulse when a frame is aborted
//   frames_sent  : completed-frame count, wrapping
module frame_encoder_param
  import ps_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 7,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter logic [7:0]  CRC_INIT    = 8'hFF,
  parameter int unsigned MIN_IDLE    = 1,
  parameter logic [7:0]  SOF_K       = K28_1,
  parameter logic [7:0]  EOF_K       = K29_7,
  parameter logic [7:0]  IDLE_K      = K28_5,
  parameter logic [7:0]  ABORT_K     = K30_7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_ce,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  tx_char,
  output logic        tx_k,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  localparam int unsigned BW = $clog2(PAYLOAD_LEN + 1);
  localparam int unsigned IW = $clog2(MIN_IDLE + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(PAYLOAD_LEN - 1);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(MIN_IDLE);

  state_t          state;
  logic [BW-1:0]   byte_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [7:0]      crc_next;
  logic            crc_init;
  logic            crc_en;
  logic            idle_done;

  assign s_ready   = tx_ce & (state == PAYLOAD) & ~reset;
  assign crc_init  = tx_ce & (state == SOF);
  assign crc_en    = s_ready & s_valid;
  assign idle_done = (32'(idle_cnt) + 32'd1) >= MIN_IDLE;

  frame_crc8 #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk      (clk),
    .reset    (reset),
    .init     (crc_init),
    .en       (crc_en),
    .data     (s_data),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_char     <= IDLE_K;
      tx_k        <= 1'b1;
      underrun    <= 1'b0;
      frames_sent <= '0;
      idle_cnt    <= '0;
      byte_cnt    <= '0;
    end else begin
      underrun <= 1'b0;
      if (tx_ce) begin
        unique case (state)
          IDLE: begin
            tx_char <= IDLE_K;
            tx_k    <= 1'b1;
            if (idle_cnt != IDLE_SAT) idle_cnt <= idle_cnt + 1'b1;
            if (s_valid && idle_done) state <= SOF;
          end
          SOF: begin
            tx_char  <= SOF_K;
            tx_k     <= 1'b1;
            byte_cnt <= '0;
            state    <= PAYLOAD;
          end
          PAYLOAD: begin
            if (s_valid) begin
              tx_char  <= s_data;
              tx_k     <= 1'b0;
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == LAST_BYTE) state <= CRC;
            end else begin
              tx_char  <= ABORT_K;
              tx_k     <= 1'b1;
              underrun <= 1'b1;
              idle_cnt <= '0;
              state    <= IDLE;
            end
          end
          CRC: begin
            // CRC engine is idle here, so crc_next is the accumulated payload CRC.
            tx_char <= crc_next;
            tx_k    <= 1'b0;
            state   <= EOF;
          end
          EOF: begin
            tx_char     <= EOF_K;
            tx_k        <= 1'b1;
            frames_sent <= frames_sent + 16'd1;
            idle_cnt    <= '0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_encoder_param.sv
// Randomised bench for frame_encoder_param. Three instances with different
// PAYLOAD_LEN / MIN_IDLE run side by side against a frame-level reference
// model (position within the frame, queue of accepted bytes, CRC computed
// over the whole queue bit-serially).
module tb_frame_encoder_param;

  localparam int NDUT = 3;
  localparam int LENS [NDUT] = '{7, 1, 7};
  localparam int MINS [NDUT] = '{1, 1, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_ce;
  logic [7:0]  s_data      [NDUT];
  logic        s_valid     [NDUT];
  logic        s_ready     [NDUT];
  logic [7:0]  tx_char     [NDUT];
  logic        tx_k        [NDUT];
  logic        underrun    [NDUT];
  logic [15:0] frames_sent [NDUT];

  always #5 clk = ~clk;

  frame_encoder_param #(.PAYLOAD_LEN(7), .MIN_IDLE(1)) u_dut0 (
    .clk(clk), .reset(reset), .tx_ce(tx_ce), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .tx_char(tx_char[0]), .tx_k(tx_k[0]), .underrun(underrun[0]),
    .frames_sent(frames_sent[0]));

  frame_encoder_param #(.PAYLOAD_LEN(1), .MIN_IDLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_ce(tx_ce), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .tx_char(tx_char[1]), .tx_k(tx_k[1]), .underrun(underrun[1]),
    .frames_sent(frames_sent[1]));

  frame_encoder_param #(.PAYLOAD_LEN(7), .MIN_IDLE(4)) u_dut2 (
    .clk(clk), .reset(reset), .tx_ce(tx_ce), .s_data(s_data[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .tx_char(tx_char[2]), .tx_k(tx_k[2]), .underrun(underrun[2]),
    .frames_sent(frames_sent[2]));

  // Reference model: pos = -1 between frames, 0 = SOF, 1..LEN = payload
  // byte, LEN+1 = CRC, LEN+2 = EOF. gap counts IDLE chars since EOF/abort.
  int         pos    [NDUT];
  int         gap    [NDUT];
  int         frames [NDUT];
  logic [7:0] fbytes [NDUT][$];
  logic [7:0] exp_char  [NDUT];
  logic       exp_k     [NDUT];
  logic       exp_under [NDUT];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Message-bit-serial CRC-8, poly 0x07, seed 0xFF, no reflection / final XOR.
  function automatic logic [7:0] ref_crc(input logic [7:0] msg [$]);
    logic [7:0] r;
    logic       fb;
    r = 8'hFF;
    foreach (msg[b]) begin
      for (int j = 7; j >= 0; j--) begin
        fb = r[7] ^ msg[b][j];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NDUT; i++) begin
      exp_under[i] = 1'b0;
      if (reset) begin
        pos[i] = -1; gap[i] = 0; frames[i] = 0;
        exp_char[i] = 8'hBC; exp_k[i] = 1'b1;
      end else if (tx_ce) begin
        if (pos[i] < 0) begin
          exp_char[i] = 8'hBC; exp_k[i] = 1'b1;
          gap[i]++;
          if (s_valid[i] && gap[i] >= MINS[i]) pos[i] = 0;
        end else if (pos[i] == 0) begin
          exp_char[i] = 8'h3C; exp_k[i] = 1'b1;
          fbytes[i].delete();
          pos[i] = 1;
        end else if (pos[i] <= LENS[i]) begin
          if (s_valid[i]) begin
            exp_char[i] = s_data[i]; exp_k[i] = 1'b0;
            fbytes[i].push_back(s_data[i]);
            pos[i]++;
          end else begin
            exp_char[i] = 8'hFE; exp_k[i] = 1'b1;
            exp_under[i] = 1'b1;
            gap[i] = 0; pos[i] = -1;
          end
        end else if (pos[i] == LENS[i] + 1) begin
          exp_char[i] = ref_crc(fbytes[i]); exp_k[i] = 1'b0;
          pos[i]++;
        end else begin
          exp_char[i] = 8'hFD; exp_k[i] = 1'b1;
          frames[i] = (frames[i] + 1) % 65536;
          gap[i] = 0; pos[i] = -1;
        end
      end
    end
  endtask

  // Inputs are already driven (after a negedge); check s_ready, advance the
  // model, then compare registered outputs just after the edge.
  task automatic tick();
    logic want_ready;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      want_ready = tx_ce && !reset && pos[i] >= 1 && pos[i] <= LENS[i];
      check($sformatf("d%0d s_ready", i), 32'(s_ready[i]), 32'(want_ready));
    end
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("d%0d tx_char", i), 32'(tx_char[i]), 32'(exp_char[i]));
      check($sformatf("d%0d tx_k", i), 32'(tx_k[i]), 32'(exp_k[i]));
      check($sformatf("d%0d underrun", i), 32'(underrun[i]), 32'(exp_under[i]));
      check($sformatf("d%0d frames_sent", i), 32'(frames_sent[i]), 32'(frames[i]));
    end
  endtask

  task automatic drive_random(input int valid_pct);
    for (int i = 0; i < NDUT; i++) begin
      s_valid[i] = ($urandom_range(99) < valid_pct);
      s_data[i]  = 8'($urandom);
    end
  endtask

  task automatic drive_fixed(input logic v, input logic [7:0] d);
    for (int i = 0; i < NDUT; i++) begin
      s_valid[i] = v;
      s_data[i]  = d;
    end
  endtask

  initial begin
    reset = 1'b1;
    tx_ce = 1'b1;
    drive_fixed(1'b0, 8'h00);
    for (int i = 0; i < NDUT; i++) begin
      pos[i] = -1; gap[i] = 0; frames[i] = 0;
    end

    // Reset, then a long idle stretch with no source data.
    @(negedge clk);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive_fixed(1'b0, 8'h00);
      tick();
    end

    // Held-valid constant payloads: 0x00 then 0xFF.
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      drive_fixed(1'b1, 8'h00);
      tick();
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      drive_fixed(1'b1, 8'hFF);
      tick();
    end

    // Random data with occasional source gaps (aborts), tx_ce always on.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive_random(94);
      tick();
    end

    // Character enable toggling every cycle.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      tx_ce = c[0];
      drive_random(96);
      tick();
    end

    // Random enable plus sporadic resets, some landing mid-frame.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      tx_ce = ($urandom_range(3) != 0);
      reset = ($urandom_range(49) == 0);
      drive_random(95);
      tick();
    end

    reset = 1'b0;
    tx_ce = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive_fixed(1'b1, 8'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
